// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM host arbiter.
// Holds the FSM encoding and the port-select constants used by top and grant logic.
package sdram_pkg;

    localparam int unsigned DEF_HADDR_WIDTH = 24;
    localparam int unsigned DEF_DATA_WIDTH  = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/sdram_arb_grant.sv
// Combinational grant select between client ports A and B.
// SDRAM_ARB_ROUND_ROBIN_EN: collisions go to the port not granted last; otherwise A wins.
module sdram_arb_grant
    import sdram_pkg::*;
(
    input  logic a_req_i,
    input  logic b_req_i,
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    input  logic rr_ptr_i,
`endif
    output logic grant_o
);

    always_comb begin
        grant_o = PORT_A;
        if (b_req_i && !a_req_i) begin
            grant_o = PORT_B;
        end
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        // rr_ptr_i holds the last granted port
        if (a_req_i && b_req_i) begin
            grant_o = ~rr_ptr_i;
        end
`endif
    end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Two-client front end for sdram_controller: one word transaction at a time, refresh-tolerant.
// Optional SDRAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed A-over-B priority.
module sdram_host_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned HADDR_WIDTH = DEF_HADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_req_i,
    input  logic                   a_we_i,
    input  logic [HADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0]  a_wdata_i,
    output logic                   a_ack_o,
    output logic [DATA_WIDTH-1:0]  a_rdata_o,
    input  logic                   b_req_i,
    input  logic                   b_we_i,
    input  logic [HADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0]  b_wdata_i,
    output logic                   b_ack_o,
    output logic [DATA_WIDTH-1:0]  b_rdata_o,
    output logic [HADDR_WIDTH-1:0] mem_wr_addr_o,
    output logic [DATA_WIDTH-1:0]  mem_wr_data_o,
    output logic                   mem_wr_enable_o,
    output logic [HADDR_WIDTH-1:0] mem_rd_addr_o,
    output logic                   mem_rd_enable_o,
    input  logic [DATA_WIDTH-1:0]  mem_rd_data_i,
    input  logic                   mem_rd_ready_i,
    input  logic                   mem_busy_i
);

    arb_state_e             state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   we_q, we_d;
    logic [HADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   rd_en_q, rd_en_d;
    logic                   wr_en_q, wr_en_d;
    logic                   a_ack_q, a_ack_d;
    logic                   b_ack_q, b_ack_d;
    logic [DATA_WIDTH-1:0]  a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0]  b_rdata_q, b_rdata_d;
    logic                   grant_sel;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic rr_q, rr_d;
`endif

    sdram_arb_grant u_grant (
        .a_req_i  (a_req_i),
        .b_req_i  (b_req_i),
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        .rr_ptr_i (rr_q),
`endif
        .grant_o  (grant_sel)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_en_d   = rd_en_q;
        wr_en_d   = wr_en_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        rr_d      = rr_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (a_req_i || b_req_i) begin
                    grant_d = grant_sel;
                    if (grant_sel == PORT_B) begin
                        we_d    = b_we_i;
                        addr_d  = b_addr_i;
                        wdata_d = b_wdata_i;
                    end else begin
                        we_d    = a_we_i;
                        addr_d  = a_addr_i;
                        wdata_d = a_wdata_i;
                    end
                    rd_en_d = ~we_d;
                    wr_en_d = we_d;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // A refresh keeps busy low; enables stay up until the controller takes us
                if (mem_busy_i) begin
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (we_q) begin
                    if (!mem_busy_i) begin
                        a_ack_d = (grant_q == PORT_A);
                        b_ack_d = (grant_q == PORT_B);
                        state_d = ARB_DONE;
                    end
                end else if (mem_rd_ready_i) begin
                    if (grant_q == PORT_B) begin
                        b_rdata_d = mem_rd_data_i;
                    end else begin
                        a_rdata_d = mem_rd_data_i;
                    end
                    a_ack_d = (grant_q == PORT_A);
                    b_ack_d = (grant_q == PORT_B);
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                rr_d = grant_q;
`endif
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            grant_q   <= PORT_A;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= PORT_A;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign a_ack_o         = a_ack_q;
    assign b_ack_o         = b_ack_q;
    assign a_rdata_o       = a_rdata_q;
    assign b_rdata_o       = b_rdata_q;
    assign mem_wr_addr_o   = addr_q;
    assign mem_rd_addr_o   = addr_q;
    assign mem_wr_data_o   = wdata_q;
    assign mem_wr_enable_o = wr_en_q;
    assign mem_rd_enable_o = rd_en_q;

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Scoreboard bench for sdram_host_arbiter against a small behavioural controller model.
// Memory word at low address byte i resets to 16'hA500 | i.
module tb_sdram_host_arbiter;
    import sdram_pkg::*;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data;
    logic          mem_wr_enable, mem_rd_enable, mem_rd_ready;
    logic          mem_busy;

    always #5 clk = ~clk;

    sdram_host_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a_req_i         (a_req),
        .a_we_i          (a_we),
        .a_addr_i        (a_addr),
        .a_wdata_i       (a_wdata),
        .a_ack_o         (a_ack),
        .a_rdata_o       (a_rdata),
        .b_req_i         (b_req),
        .b_we_i          (b_we),
        .b_addr_i        (b_addr),
        .b_wdata_i       (b_wdata),
        .b_ack_o         (b_ack),
        .b_rdata_o       (b_rdata),
        .mem_wr_addr_o   (mem_wr_addr),
        .mem_wr_data_o   (mem_wr_data),
        .mem_wr_enable_o (mem_wr_enable),
        .mem_rd_addr_o   (mem_rd_addr),
        .mem_rd_enable_o (mem_rd_enable),
        .mem_rd_data_i   (mem_rd_data),
        .mem_rd_ready_i  (mem_rd_ready),
        .mem_busy_i      (mem_busy)
    );

    // Behavioural controller: 6-cycle access, 8-cycle refresh that silently defers requests
    logic [DW-1:0] mem [256];
    int            ctl_cnt, ref_cnt;
    logic          ctl_we, ctl_rdy, ref_taken;
    logic [7:0]    ctl_addr;
    logic [DW-1:0] ctl_data;
    logic          ref_req = 1'b0, inj_rdy = 1'b0;
    int            cyc = 0;

    assign mem_rd_ready = ctl_rdy | inj_rdy;
    assign mem_rd_data  = inj_rdy ? 16'hDEAD : ctl_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_cnt <= 0; ref_cnt <= 0; ctl_we <= 1'b0; ctl_rdy <= 1'b0; ref_taken <= 1'b0;
            ctl_addr <= '0; ctl_data <= '0; mem_busy <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA500 | 16'(i);
        end else begin
            mem_busy <= (ctl_cnt != 0);
            ctl_rdy  <= 1'b0;
            if (!ref_req) ref_taken <= 1'b0;
            if (ctl_cnt != 0) begin
                ctl_cnt <= ctl_cnt - 1;
                if (ctl_cnt == 1 && !ctl_we) begin
                    ctl_rdy  <= 1'b1;
                    ctl_data <= mem[ctl_addr];
                end
            end else if (ref_cnt != 0) begin
                ref_cnt <= ref_cnt - 1;
            end else if (ref_req && !ref_taken) begin
                ref_cnt   <= 8;
                ref_taken <= 1'b1;
            end else if (mem_rd_enable || mem_wr_enable) begin
                ctl_cnt  <= 6;
                ctl_we   <= mem_wr_enable;
                ctl_addr <= mem_rd_addr[7:0];
                if (mem_wr_enable) mem[mem_wr_addr[7:0]] <= mem_wr_data;
            end
        end
    end

    typedef struct packed {
        logic          port;
        logic          we;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic push(input logic port, input logic we, input logic [DW-1:0] data);
        exp_t e;
        e.port = port; e.we = we; e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic port;
        logic [DW-1:0] rd;
        forever begin
            @(negedge clk);
            if (rst_n && (a_ack || b_ack)) begin
                check("single_ack", {63'd0, a_ack & b_ack}, 64'd0);
                port = a_ack ? PORT_A : PORT_B;
                rd   = a_ack ? a_rdata : b_rdata;
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", {63'd0, port}, 64'hFFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_port", {63'd0, port}, {63'd0, e.port});
                    if (!e.we) check("rdata", {48'd0, rd}, {48'd0, e.data});
                end
            end
        end
    endtask

    task automatic a_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bit got = 0;
        @(negedge clk);
        a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (a_ack) got = 1;
        end
        if (!got) check("a_timeout", 64'd0, 64'd1);
        a_req = 1'b0;
    endtask

    task automatic b_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bit got = 0;
        @(negedge clk);
        b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (b_ack) got = 1;
        end
        if (!got) check("b_timeout", 64'd0, 64'd1);
        b_req = 1'b0;
    endtask

    initial begin
        int  t_ack [8];
        bit  got;
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {a_ack, b_ack, a_rdata, b_rdata, mem_wr_enable, mem_rd_enable, mem_rd_addr},
              64'd0);
        rst_n = 1'b1;

        // Write then read back on A
        push(PORT_A, 1'b1, 16'h0);
        a_op(1'b1, 24'h00_1234, 16'hBEEF);
        push(PORT_A, 1'b0, 16'hBEEF);
        a_op(1'b0, 24'h00_1234, 16'h0);

        // B streams 8 reads with req held high; 10 cycles ack-to-ack means no idle gap
        for (int k = 0; k < 8; k++) push(PORT_B, 1'b0, 16'hA500 | 16'(k));
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b0; b_addr = 24'h0;
        for (int k = 0; k < 8; k++) begin
            got = 0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                if (b_ack) got = 1;
            end
            if (!got) check("stream_timeout", 64'd0, 64'd1);
            t_ack[k] = cyc;
            if (k == 7) b_req = 1'b0;
            else b_addr = 24'(k + 1);
        end
        for (int k = 1; k < 8; k++) check("stream_spacing", 64'(t_ack[k] - t_ack[k-1]), 64'd10);

        // Collision 1: last grant was B, so A goes first in both modes
        push(PORT_A, 1'b0, 16'hA510);
        push(PORT_B, 1'b0, 16'hA520);
        fork
            a_op(1'b0, 24'h10, 16'h0);
            b_op(1'b0, 24'h20, 16'h0);
        join

        // Lone A write moves the last grant to A
        push(PORT_A, 1'b1, 16'h0);
        a_op(1'b1, 24'h40, 16'h1111);

        // Collision 2: round-robin now favours B
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        push(PORT_B, 1'b0, 16'h1111);
        push(PORT_A, 1'b0, 16'hA510);
`else
        push(PORT_A, 1'b0, 16'hA510);
        push(PORT_B, 1'b0, 16'h1111);
`endif
        fork
            a_op(1'b0, 24'h10, 16'h0);
            b_op(1'b0, 24'h40, 16'h0);
        join

        // Refresh starts on the same edge the read is issued; enable must stay up
        push(PORT_A, 1'b0, 16'hBEEF);
        fork
            a_op(1'b0, 24'h00_1234, 16'h0);
            begin
                @(negedge clk);
                ref_req = 1'b1;
                repeat (4) @(negedge clk);
                check("en_held_in_refresh", {62'd0, mem_rd_enable, mem_busy}, 64'd2);
            end
        join
        ref_req = 1'b0;

        // Stray rd_ready while idle
        repeat (3) @(negedge clk);
        inj_rdy = 1'b1;
        @(negedge clk);
        inj_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_inject_rdata", {32'd0, a_rdata, b_rdata}, {32'd0, 16'hBEEF, 16'h1111});

        // Stray rd_ready while the B read is still in issue
        push(PORT_B, 1'b0, 16'hA505);
        fork
            b_op(1'b0, 24'h05, 16'h0);
            begin
                repeat (2) @(negedge clk);
                check("issue_enable", {63'd0, mem_rd_enable}, 64'd1);
                inj_rdy = 1'b1;
                @(negedge clk);
                inj_rdy = 1'b0;
            end
        join

        // Async reset while waiting on the controller abandons the access
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 24'h3;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (mem_busy && !mem_rd_enable) got = 1;
        end
        check("reached_wait", {63'd0, got}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {a_ack, b_ack, a_rdata, b_rdata, mem_wr_enable, mem_rd_enable, mem_rd_addr},
              64'd0);
        a_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_after_reset", {62'd0, mem_rd_enable, mem_wr_enable}, 64'd0);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
